// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared state encoding and J/K excitation constants for jk_seq_driver
package jk_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_DRIVE = DRIVE,
    S_CHECK = CHECK
  } state_e;

  // Excitation pairs are packed as {J, K}.
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  function automatic int step_w(input int seq_len);
    return $clog2(seq_len + 1);
  endfunction

endpackage

// File: rtl/jk_seq_driver_if.sv
// rtl/jk_seq_driver_if.sv - stimulus/response bundle between jk_seq_driver and the flip-flop under test
interface jk_seq_driver_if #(
  parameter int SEQ_LEN = 8,
  parameter int CNT_W   = 4
);

  localparam int STEP_W = $clog2(SEQ_LEN + 1);

  logic                Start;
  logic [SEQ_LEN-1:0]  TargetSeq;
  logic                Q_in;
  logic                J;
  logic                K;
  logic                Busy;
  logic                Done;
  logic                Pass;
  logic [CNT_W-1:0]    ErrCount;
  logic [STEP_W-1:0]   Step;

  modport master (
    input  Start, TargetSeq, Q_in,
    output J, K, Busy, Done, Pass, ErrCount, Step
  );

  modport slave (
    output Start, TargetSeq, Q_in,
    input  J, K, Busy, Done, Pass, ErrCount, Step
  );

endinterface

// File: rtl/jk_excite.sv
// rtl/jk_excite.sv - J/K excitation for a present/next Q pair
// JK_TOGGLE_PREF_EN selects toggle excitation for transitions instead of set/reset.
module jk_excite
  import jk_pkg::*;
(
  input  logic       q_now_i,
  input  logic       q_next_i,
  output logic [1:0] jk_o
);

  always_comb begin
    jk_o = JK_HOLD;
    if (q_now_i != q_next_i) begin
`ifdef JK_TOGGLE_PREF_EN
      jk_o = JK_TOGGLE;
`else
      jk_o = q_next_i ? JK_SET : JK_RESET;
`endif
    end
  end

endmodule

// File: rtl/jk_seq_driver.sv
// rtl/jk_seq_driver.sv - drives a JK flip-flop through a target Q sequence and counts mismatches
// Excitation style follows JK_TOGGLE_PREF_EN inside jk_excite.
module jk_seq_driver
  import jk_pkg::*;
#(
  parameter int SEQ_LEN = 8,
  parameter int CNT_W   = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  jk_seq_driver_if.master   bus
);

  localparam int                STEP_W    = step_w(SEQ_LEN);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SEQ_LEN - 1);
  localparam logic [CNT_W-1:0]  ERR_MAX   = '1;

  state_e              state_q, state_d;
  logic [SEQ_LEN-1:0]  seq_q, seq_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic                pass_q, pass_d;
  logic                done_q, done_d;
  logic                j_q, j_d;
  logic                k_q, k_d;

  logic [STEP_W-1:0]   next_idx;
  logic [SEQ_LEN-1:0]  next_sh;
  logic [SEQ_LEN-1:0]  now_sh;
  logic                tgt_next;
  logic                tgt_now;
  logic [1:0]          jk_exc;
  logic [CNT_W-1:0]    err_inc;

  // The excitation target is TargetSeq[0] when starting, else the following step's bit.
  always_comb begin
    next_idx = (state_q == S_CHECK) ? step_q + 1'b1 : '0;
    next_sh  = (state_q == S_IDLE) ? bus.TargetSeq : (seq_q >> next_idx);
    now_sh   = seq_q >> step_q;
    tgt_next = next_sh[0];
    tgt_now  = now_sh[0];
    err_inc  = (err_q == ERR_MAX) ? err_q : err_q + 1'b1;
  end

  jk_excite u_excite (
    .q_now_i  (bus.Q_in),
    .q_next_i (tgt_next),
    .jk_o     (jk_exc)
  );

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    step_d  = step_q;
    err_d   = err_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    j_d     = 1'b0;
    k_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          seq_d      = bus.TargetSeq;
          step_d     = '0;
          err_d      = '0;
          pass_d     = 1'b0;
          {j_d, k_d} = jk_exc;
          state_d    = S_DRIVE;
        end
      end

      S_DRIVE: begin
        state_d = S_CHECK;
      end

      S_CHECK: begin
        if (bus.Q_in != tgt_now) begin
          err_d = err_inc;
        end
        if (step_q == LAST_STEP) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          step_d     = step_q + 1'b1;
          {j_d, k_d} = jk_exc;
          state_d    = S_DRIVE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      seq_q   <= '0;
      step_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      step_q  <= step_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  assign bus.J        = j_q;
  assign bus.K        = k_q;
  assign bus.Busy     = (state_q != S_IDLE);
  assign bus.Done     = done_q;
  assign bus.Pass     = pass_q;
  assign bus.ErrCount = err_q;
  assign bus.Step     = step_q;

endmodule

// File: tb/tb_jk_seq_driver.sv
// tb/tb_jk_seq_driver.sv - directed self-checking bench for jk_seq_driver
module tb_jk_seq_driver;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] tseq;
  logic       use_ff;
  logic       ff_q;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef JK_TOGGLE_PREF_EN
  localparam logic EXP_K_SET = 1'b1;
  localparam logic EXP_J_RST = 1'b1;
`else
  localparam logic EXP_K_SET = 1'b0;
  localparam logic EXP_J_RST = 1'b0;
`endif

  jk_seq_driver_if #(.SEQ_LEN(8), .CNT_W(4)) ifa ();
  jk_seq_driver_if #(.SEQ_LEN(8), .CNT_W(2)) ifb ();

  jk_seq_driver #(.SEQ_LEN(8), .CNT_W(4)) dut_a (
    .Clk   (clk),
    .Reset (rst),
    .bus   (ifa.master)
  );

  jk_seq_driver #(.SEQ_LEN(8), .CNT_W(2)) dut_b (
    .Clk   (clk),
    .Reset (rst),
    .bus   (ifb.master)
  );

  assign ifa.Start     = start;
  assign ifa.TargetSeq = tseq;
  assign ifa.Q_in      = use_ff ? ff_q : 1'b0;
  assign ifb.Start     = start;
  assign ifb.TargetSeq = tseq;
  assign ifb.Q_in      = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference JK flip-flop driven by dut_a
  always @(posedge clk or posedge rst) begin
    if (rst) ff_q <= 1'b0;
    else begin
      case ({ifa.J, ifa.K})
        2'b01:   ff_q <= 1'b0;
        2'b10:   ff_q <= 1'b1;
        2'b11:   ff_q <= ~ff_q;
        default: ff_q <= ff_q;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // lat = edges from the accepted Start edge to the edge raising Done (-1 on timeout)
  task automatic run_seq(input logic [7:0] seq, input bit repulse,
                         output int lat, output logic [7:0] jv, output logic [7:0] kv);
    int cnt;
    jv    = '0;
    kv    = '0;
    tseq  = seq;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    jv[0] = ifa.J;
    kv[0] = ifa.K;
    cnt   = 0;
    lat   = -1;
    while (cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (repulse && cnt == 5) begin
        start = 1'b1;
        tseq  = 8'hFF;
      end else if (repulse && cnt == 6) begin
        start = 1'b0;
        tseq  = seq;
      end
      if ((cnt % 2) == 0 && cnt < 16) begin
        jv[3'(cnt / 2)] = ifa.J;
        kv[3'(cnt / 2)] = ifa.K;
      end
      if (ifa.Done) begin
        lat = cnt;
        break;
      end
    end
  endtask

  initial begin
    int         lat;
    int         dones;
    logic [7:0] jv;
    logic [7:0] kv;

    rst    = 1'b1;
    start  = 1'b0;
    tseq   = 8'h00;
    use_ff = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_J",    32'(ifa.J), 32'd0);
    check("rst_K",    32'(ifa.K), 32'd0);
    check("rst_Busy", 32'(ifa.Busy), 32'd0);
    check("rst_Done", 32'(ifa.Done), 32'd0);
    check("rst_Pass", 32'(ifa.Pass), 32'd0);
    check("rst_Err",  32'(ifa.ErrCount), 32'd0);
    check("rst_Step", 32'(ifa.Step), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Correct flip-flop, Q starts at 0
    run_seq(8'b1010_0110, 1'b0, lat, jv, kv);
    check("t1_s0_J", 32'(jv[0]), 32'd0);
    check("t1_s0_K", 32'(kv[0]), 32'd0);
    check("t1_s1_J", 32'(jv[1]), 32'd1);
    check("t1_s1_K", 32'(kv[1]), 32'(EXP_K_SET));
    check("t1_s3_J", 32'(jv[3]), 32'(EXP_J_RST));
    check("t1_s3_K", 32'(kv[3]), 32'd1);
    check("t1_lat",  32'(lat), 32'd16);
    check("t1_pass", 32'(ifa.Pass), 32'd1);
    check("t1_err",  32'(ifa.ErrCount), 32'd0);
    check("t1_step", 32'(ifa.Step), 32'd7);
    @(negedge clk);
    check("t1_done_pulse", 32'(ifa.Done), 32'd0);
    check("t1_busy_end",   32'(ifa.Busy), 32'd0);
    repeat (3) @(negedge clk);
    check("t1_pass_hold",  32'(ifa.Pass), 32'd1);

    // Q_in stuck at 0, all-ones target
    use_ff = 1'b0;
    run_seq(8'hFF, 1'b0, lat, jv, kv);
    check("t2_jv",    32'(jv), 32'h0000_00FF);
    check("t2_kv",    32'(kv), EXP_K_SET ? 32'h0000_00FF : 32'h0);
    check("t2_lat",   32'(lat), 32'd16);
    check("t2_err",   32'(ifa.ErrCount), 32'd8);
    check("t2_pass",  32'(ifa.Pass), 32'd0);
    check("t2_b_err", 32'(ifb.ErrCount), 32'd3);
    check("t2_b_pass",32'(ifb.Pass), 32'd0);
    repeat (2) @(negedge clk);
    check("t2_err_hold", 32'(ifa.ErrCount), 32'd8);

    // Start re-pulsed mid-run with a different sequence is ignored
    run_seq(8'b1010_0110, 1'b1, lat, jv, kv);
    check("t3_lat",  32'(lat), 32'd16);
    check("t3_err",  32'(ifa.ErrCount), 32'd4);
    check("t3_pass", 32'(ifa.Pass), 32'd0);
    repeat (2) @(negedge clk);

    // Reset during step 3 DRIVE
    use_ff = 1'b1;
    tseq   = 8'b1010_0110;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("t4_busy_pre", 32'(ifa.Busy), 32'd1);
    check("t4_step_pre", 32'(ifa.Step), 32'd3);
    rst = 1'b1;
    #1;
    check("t4_J",    32'(ifa.J), 32'd0);
    check("t4_K",    32'(ifa.K), 32'd0);
    check("t4_Busy", 32'(ifa.Busy), 32'd0);
    check("t4_Err",  32'(ifa.ErrCount), 32'd0);
    check("t4_Step", 32'(ifa.Step), 32'd0);
    check("t4_Pass", 32'(ifa.Pass), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (ifa.Done) dones++;
    end
    check("t4_no_done", 32'(dones), 32'd0);

    // Clean run after reset: 0 -> 1 -> 0 transitions
    run_seq(8'b0000_0010, 1'b0, lat, jv, kv);
    check("t5_s1_J", 32'(jv[1]), 32'd1);
    check("t5_s1_K", 32'(kv[1]), 32'(EXP_K_SET));
    check("t5_s2_J", 32'(jv[2]), 32'(EXP_J_RST));
    check("t5_s2_K", 32'(kv[2]), 32'd1);
    check("t5_lat",  32'(lat), 32'd16);
    check("t5_pass", 32'(ifa.Pass), 32'd1);
    check("t5_err",  32'(ifa.ErrCount), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
